// File: rtl/alu_sequencer.sv
// alu_sequencer: request-driven controller for the 8-bit ALU.
// Accepts one operation per req valid/ready handshake, optionally preloads the ALU
// carry flag (PRESET), executes the op exactly once (EXEC), samples the ALU result
// and flags (CAPTURE), then returns result, flags and branch-taken on the response
// channel (RESP).
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_req_*, o_req_ready     request channel (op, operands, carry-in, condition)
//   o_alu_fun_sel/a/b        drive ALU FunSel and operands
//   i_alu_out, i_alu_flags   ALU OutALU and ZCNO ([3]=Z, [2]=C, [1]=N, [0]=O)
//   o_resp_*, i_resp_ready   response channel (result, flags, taken)
module alu_sequencer (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic [3:0] i_req_op,
  input  logic [7:0] i_req_a,
  input  logic [7:0] i_req_b,
  input  logic       i_req_carry_in,
  input  logic [2:0] i_req_cond,
  output logic [3:0] o_alu_fun_sel,
  output logic [7:0] o_alu_a,
  output logic [7:0] o_alu_b,
  input  logic [7:0] i_alu_out,
  input  logic [3:0] i_alu_flags,
  output logic       o_resp_valid,
  input  logic       i_resp_ready,
  output logic [7:0] o_resp_result,
  output logic [3:0] o_resp_flags,
  output logic       o_resp_taken
);

  localparam logic [3:0] FunPassA = 4'h0;
  localparam logic [3:0] FunLsl   = 4'hB;
  localparam logic [3:0] OpAddC   = 4'h4;
  localparam logic [3:0] OpCsr    = 4'hF;

  typedef enum logic [2:0] {StIdle, StPreset, StExec, StCapture, StResp} state_e;

  state_e     r_state, w_state_next;
  logic [3:0] r_op;
  logic [7:0] r_a, r_b;
  logic       r_cin;
  logic [2:0] r_cond;
  logic       r_track_c, r_c_known;
  logic [7:0] r_resp_result;
  logic [3:0] r_resp_flags;
  logic       r_resp_taken;
  logic       w_need_c;
  logic       w_taken;

  // Preset only when the op consumes carry and the ALU carry is not already correct.
  assign w_need_c = ((i_req_op == OpAddC) || (i_req_op == OpCsr)) &&
                    (!r_c_known || (r_track_c != i_req_carry_in));

  // Branch condition evaluated on the flags being captured this cycle.
  always_comb begin
    w_taken = 1'b0;
    unique case (r_cond)
      3'd0: w_taken = 1'b1;
      3'd1: w_taken = i_alu_flags[3];
      3'd2: w_taken = ~i_alu_flags[3];
      3'd3: w_taken = i_alu_flags[2];
      3'd4: w_taken = ~i_alu_flags[2];
      3'd5: w_taken = i_alu_flags[1];
      3'd6: w_taken = ~i_alu_flags[1];
      3'd7: w_taken = i_alu_flags[0];
      default: w_taken = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (i_req_valid) w_state_next = w_need_c ? StPreset : StExec;
      StPreset:  w_state_next = StExec;
      StExec:    w_state_next = StCapture;
      StCapture: w_state_next = StResp;
      StResp:    if (i_resp_ready) w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  // Outputs: the latched op reaches FunSel only in EXEC, so it executes exactly once.
  always_comb begin
    o_req_ready   = 1'b0;
    o_resp_valid  = 1'b0;
    o_alu_fun_sel = FunPassA;
    o_alu_a       = r_a;
    o_alu_b       = r_b;
    unique case (r_state)
      StIdle:  o_req_ready = 1'b1;
      StPreset: begin
        // LSL shifts the requested carry out of bit 7 into the ALU C flag.
        o_alu_fun_sel = FunLsl;
        o_alu_a       = {r_cin, 7'b0};
        o_alu_b       = 8'h00;
      end
      StExec:    o_alu_fun_sel = r_op;
      StCapture: o_alu_fun_sel = FunPassA;
      StResp:    o_resp_valid  = 1'b1;
      default:   o_alu_fun_sel = FunPassA;
    endcase
  end

  // Request latch, carry tracking and response capture
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_op          <= 4'h0;
      r_a           <= 8'h00;
      r_b           <= 8'h00;
      r_cin         <= 1'b0;
      r_cond        <= 3'd0;
      r_track_c     <= 1'b0;
      r_c_known     <= 1'b0;
      r_resp_result <= 8'h00;
      r_resp_flags  <= 4'h0;
      r_resp_taken  <= 1'b0;
    end else begin
      if ((r_state == StIdle) && i_req_valid) begin
        r_op   <= i_req_op;
        r_a    <= i_req_a;
        r_b    <= i_req_b;
        r_cin  <= i_req_carry_in;
        r_cond <= i_req_cond;
      end
      if (r_state == StPreset) begin
        r_track_c <= r_cin;
        r_c_known <= 1'b1;
      end
      if (r_state == StCapture) begin
        r_resp_result <= i_alu_out;
        r_resp_flags  <= i_alu_flags;
        r_resp_taken  <= w_taken;
        r_track_c     <= i_alu_flags[2];
        r_c_known     <= 1'b1;
      end
    end
  end

  assign o_resp_result = r_resp_result;
  assign o_resp_flags  = r_resp_flags;
  assign o_resp_taken  = r_resp_taken;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

  logic       i_clk;
  logic       i_reset;
  logic       i_req_valid;
  logic       o_req_ready;
  logic [3:0] i_req_op;
  logic [7:0] i_req_a;
  logic [7:0] i_req_b;
  logic       i_req_carry_in;
  logic [2:0] i_req_cond;
  logic [3:0] o_alu_fun_sel;
  logic [7:0] o_alu_a;
  logic [7:0] o_alu_b;
  logic [7:0] i_alu_out;
  logic [3:0] i_alu_flags;
  logic       o_resp_valid;
  logic       i_resp_ready;
  logic [7:0] o_resp_result;
  logic [3:0] o_resp_flags;
  logic       o_resp_taken;

  alu_sequencer u_dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_req_valid    (i_req_valid),
    .o_req_ready    (o_req_ready),
    .i_req_op       (i_req_op),
    .i_req_a        (i_req_a),
    .i_req_b        (i_req_b),
    .i_req_carry_in (i_req_carry_in),
    .i_req_cond     (i_req_cond),
    .o_alu_fun_sel  (o_alu_fun_sel),
    .o_alu_a        (o_alu_a),
    .o_alu_b        (o_alu_b),
    .i_alu_out      (i_alu_out),
    .i_alu_flags    (i_alu_flags),
    .o_resp_valid   (o_resp_valid),
    .i_resp_ready   (i_resp_ready),
    .o_resp_result  (o_resp_result),
    .o_resp_flags   (o_resp_flags),
    .o_resp_taken   (o_resp_taken)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural ALU: registered OutALU/ZCNO. Returns {Z,C,N,O,result}.
  function automatic logic [11:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic c, input logic o);
    logic [8:0] s;
    logic [7:0] r;
    logic       nc, no;
    nc = c;
    no = o;
    r  = a;
    s  = 9'd0;
    case (op)
      4'h0: r = a;
      4'h1: r = b;
      4'h2: r = ~a;
      4'h3: r = ~b;
      4'h4: begin
        s = {1'b0, a} + {1'b0, b} + {8'b0, c};
        r = s[7:0]; nc = s[8]; no = (a[7] == b[7]) && (r[7] != a[7]);
      end
      4'h5: begin
        s = {1'b0, a} + {1'b0, ~b} + 9'd1;
        r = s[7:0]; nc = s[8]; no = (a[7] != b[7]) && (r[7] != a[7]);
      end
      4'h6: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[7:0]; nc = s[8]; no = (a[7] == b[7]) && (r[7] != a[7]);
      end
      4'h7: r = a & b;
      4'h8: r = a | b;
      4'h9: r = a ^ b;
      4'hA: r = ~(a & b);
      4'hB: begin r = {a[6:0], 1'b0}; nc = a[7]; end
      4'hC: begin r = {1'b0, a[7:1]}; nc = a[0]; end
      4'hD: begin r = {a[7], a[7:1]}; nc = a[0]; end
      4'hE: begin r = {a[6:0], c};    nc = a[7]; end
      default: begin r = {c, a[7:1]}; nc = a[0]; end
    endcase
    return {(r == 8'h00), nc, r[7], no, r};
  endfunction

  function automatic logic cond_f(input logic [2:0] cond, input logic [3:0] f);
    case (cond)
      3'd0: return 1'b1;
      3'd1: return f[3];
      3'd2: return ~f[3];
      3'd3: return f[2];
      3'd4: return ~f[2];
      3'd5: return f[1];
      3'd6: return ~f[1];
      default: return f[0];
    endcase
  endfunction

  logic [7:0] alu_out_q   = 8'h00;
  logic [3:0] alu_flags_q = 4'h0;
  always @(posedge i_clk) begin
    {alu_flags_q, alu_out_q} <= alu_f(o_alu_fun_sel, o_alu_a, o_alu_b,
                                      alu_flags_q[2], alu_flags_q[0]);
  end
  assign i_alu_out   = alu_out_q;
  assign i_alu_flags = alu_flags_q;

  // Bench-side knowledge of the ALU carry/overflow and of the sequencer's carry tracking.
  logic       exp_c, exp_o, tb_track, tb_known;
  logic [7:0] last_res;
  logic [3:0] last_flags;
  logic       last_taken;
  int         last_lat;

  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic [2:0] cond, input int hold);
    logic        carry_op, exp_preset, seq_ok;
    logic [11:0] m;
    logic [3:0]  expf;
    int          lat, wait_n;
    carry_op   = (op == 4'h4) || (op == 4'hF);
    exp_preset = carry_op && (!tb_known || (tb_track != cin));
    m          = alu_f(op, a, b, carry_op ? cin : exp_c, exp_o);
    wait_n = 0;
    while (!o_req_ready && wait_n < 20) begin
      @(negedge i_clk);
      wait_n++;
    end
    check("req_ready_before", o_req_ready, 1);
    i_req_valid    = 1'b1;
    i_req_op       = op;
    i_req_a        = a;
    i_req_b        = b;
    i_req_carry_in = cin;
    i_req_cond     = cond;
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    i_req_a     = ~a;
    seq_ok      = 1'b1;
    lat         = 1;
    @(negedge i_clk);
    while (!o_resp_valid && lat < 8) begin
      if (exp_preset) expf = (lat == 1) ? 4'hB : ((lat == 2) ? op : 4'h0);
      else            expf = (lat == 1) ? op : 4'h0;
      if (o_alu_fun_sel !== expf) seq_ok = 1'b0;
      if (o_req_ready !== 1'b0) seq_ok = 1'b0;
      if (exp_preset && lat == 1 && (o_alu_a !== {cin, 7'b0} || o_alu_b !== 8'h00)) seq_ok = 1'b0;
      if (expf == op && ((exp_preset && lat == 2) || (!exp_preset && lat == 1)) &&
          (o_alu_a !== a || o_alu_b !== b)) seq_ok = 1'b0;
      @(negedge i_clk);
      lat++;
    end
    check("latency", lat, exp_preset ? 4 : 3);
    check("funsel_seq", seq_ok, 1);
    check("result", o_resp_result, m[7:0]);
    check("flags", o_resp_flags, m[11:8]);
    check("taken", o_resp_taken, cond_f(cond, m[11:8]));
    check("funsel_resp", o_alu_fun_sel, 4'h0);
    last_res   = o_resp_result;
    last_flags = o_resp_flags;
    last_taken = o_resp_taken;
    last_lat   = lat;
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) @(negedge i_clk);
      check("hold_valid", o_resp_valid, 1);
      check("hold_ready", o_req_ready, 0);
      check("hold_result", o_resp_result, m[7:0]);
      check("hold_flags", o_resp_flags, m[11:8]);
    end
    i_resp_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_resp_ready = 1'b0;
    @(negedge i_clk);
    check("idle_valid", o_resp_valid, 0);
    check("idle_ready", o_req_ready, 1);
    exp_c    = m[10];
    exp_o    = m[8];
    tb_track = m[10];
    tb_known = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    i_reset        = 1'b1;
    i_req_valid    = 1'b0;
    i_req_op       = 4'h0;
    i_req_a        = 8'h00;
    i_req_b        = 8'h00;
    i_req_carry_in = 1'b0;
    i_req_cond     = 3'd0;
    i_resp_ready   = 1'b0;
    exp_c = 1'b0; exp_o = 1'b0; tb_track = 1'b0; tb_known = 1'b0;
    repeat (3) @(posedge i_clk);
    #1 i_reset = 1'b0;
    @(negedge i_clk);
    check("rst_req_ready", o_req_ready, 1);
    check("rst_resp_valid", o_resp_valid, 0);
    check("rst_result", o_resp_result, 0);
    check("rst_flags", o_resp_flags, 0);
    check("rst_taken", o_resp_taken, 0);
    check("rst_funsel", o_alu_fun_sel, 0);
    check("rst_alu_a", o_alu_a, 0);
    check("rst_alu_b", o_alu_b, 0);

    // Add with carry after reset: preset inserted.
    run_op(4'h4, 8'h7F, 8'h01, 1'b0, 3'd7, 0);
    check("t1_lat", last_lat, 4);
    check("t1_res", last_res, 8'h80);
    check("t1_flags", last_flags, 4'b0011);
    check("t1_taken", last_taken, 1);
    // Carry already zero: no preset.
    run_op(4'h4, 8'hFF, 8'h01, 1'b0, 3'd3, 0);
    check("t2_lat", last_lat, 3);
    check("t2_res", last_res, 8'h00);
    check("t2_flags", last_flags, 4'b1100);
    check("t2_taken", last_taken, 1);
    // CSR with tracked carry 1: no preset.
    run_op(4'hF, 8'h02, 8'h00, 1'b1, 3'd5, 0);
    check("t3_lat", last_lat, 3);
    check("t3_res", last_res, 8'h81);
    check("t3_c", last_flags[2], 0);
    check("t3_n", last_flags[1], 1);
    // Same CSR, tracked carry now 0: preset.
    run_op(4'hF, 8'h02, 8'h00, 1'b1, 3'd0, 0);
    check("t4_lat", last_lat, 4);
    check("t4_res", last_res, 8'h81);
    // Back-pressure for 10 cycles.
    run_op(4'h7, 8'hF0, 8'h3C, 1'b0, 3'd2, 10);
    check("t5_res", last_res, 8'h30);
    run_op(4'h9, 8'hA5, 8'h0F, 1'b0, 3'd0, 0);
    check("t6_res", last_res, 8'hAA);

    // Reset while in EXEC.
    @(negedge i_clk);
    i_req_valid = 1'b1; i_req_op = 4'h4; i_req_a = 8'h11; i_req_b = 8'h22;
    i_req_carry_in = 1'b1; i_req_cond = 3'd0;
    @(posedge i_clk);
    #1 i_req_valid = 1'b0;
    n = 0;
    @(negedge i_clk);
    while (o_alu_fun_sel !== 4'h4 && n < 6) begin
      @(negedge i_clk);
      n++;
    end
    check("rst_exec_reached", o_alu_fun_sel, 4'h4);
    i_reset = 1'b1;
    @(posedge i_clk);
    #1 i_reset = 1'b0;
    @(negedge i_clk);
    check("rst_exec_valid", o_resp_valid, 0);
    check("rst_exec_funsel", o_alu_fun_sel, 0);
    check("rst_exec_ready", o_req_ready, 1);
    tb_known = 1'b0;
    run_op(4'h4, 8'h10, 8'h20, 1'b0, 3'd0, 0);
    check("rst_represet_lat", last_lat, 4);
    check("rst_represet_res", last_res, 8'h30);

    // Random sequence; FunSel pattern is checked per request inside run_op.
    for (int k = 0; k < 200; k++) begin
      run_op(4'($urandom_range(15)), 8'($urandom), 8'($urandom), 1'($urandom),
             3'($urandom_range(7)), int'($urandom_range(2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
